wake_ctrl: RTL and testbench

//  Wake-decision sequencer between the classifier result stream and the wake pin.

---
 rtl/wake_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_wake_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wake_ctrl.sv
`default_nettype none
// ============================================================================
//  wake_ctrl : debounced keyword wake sequencer with programmable sustain,
//              holdoff and sticky host interrupt.
//  Rev 1.0
// ============================================================================
module wake_ctrl #(
    parameter int NUM_CLASSES = 3,
    parameter int WIN_BW      = 8,
    parameter int CNT_BW      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_CLASSES-1:0] data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    input  logic                   enable_i,
    input  logic [WIN_BW-1:0]      cfg_hits_i,
    input  logic [WIN_BW-1:0]      cfg_window_i,
    input  logic [CNT_BW-1:0]      cfg_sustain_i,
    input  logic [CNT_BW-1:0]      cfg_holdoff_i,
    input  logic                   irq_ack_i,
    output logic                   wake_o,
    output logic                   irq_o,
    output logic [WIN_BW-1:0]      hit_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_WAKE    = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_wake;
    logic              r_irq;
    logic [WIN_BW-1:0] r_hit_cnt;
    logic [WIN_BW-1:0] r_win_cnt;
    logic [CNT_BW-1:0] r_cnt;
    logic [WIN_BW-1:0] r_cfg_hits;
    logic [WIN_BW-1:0] r_cfg_window;
    logic [CNT_BW-1:0] r_cfg_sustain;
    logic [CNT_BW-1:0] r_cfg_holdoff;

    logic              w_accept;
    logic              w_hit;
    logic              w_to_wake;
    logic              w_unused_data;
    logic [WIN_BW-1:0] w_hits_raw;
    logic [WIN_BW-1:0] w_window_raw;
    logic [CNT_BW-1:0] w_sustain_raw;
    logic [WIN_BW-1:0] w_hits;
    logic [WIN_BW-1:0] w_window;
    logic [CNT_BW-1:0] w_sustain;
    logic [CNT_BW-1:0] w_holdoff;
    logic [WIN_BW-1:0] w_hit_next;
    logic [WIN_BW-1:0] w_win_next;

    // Live config while IDLE, the shadow copy once a window/wake is in flight
    assign w_hits_raw    = (r_state == S_IDLE) ? cfg_hits_i    : r_cfg_hits;
    assign w_window_raw  = (r_state == S_IDLE) ? cfg_window_i  : r_cfg_window;
    assign w_sustain_raw = (r_state == S_IDLE) ? cfg_sustain_i : r_cfg_sustain;
    assign w_holdoff     = (r_state == S_IDLE) ? cfg_holdoff_i : r_cfg_holdoff;

    assign w_hits    = (w_hits_raw == '0) ? WIN_BW'(1) : w_hits_raw;
    assign w_window  = (w_window_raw < w_hits) ? w_hits : w_window_raw;
    assign w_sustain = (w_sustain_raw == '0) ? CNT_BW'(1) : w_sustain_raw;

    assign w_accept      = valid_i & r_ready;
    assign w_hit         = w_accept & data_i[0];
    assign w_unused_data = ^data_i;
    assign w_hit_next    = r_hit_cnt + {{(WIN_BW-1){1'b0}}, w_hit};
    assign w_win_next    = r_win_cnt + WIN_BW'(1);

    assign w_to_wake = enable_i &
                       (((r_state == S_IDLE)  & w_hit & (w_hits == WIN_BW'(1))) |
                        ((r_state == S_ARMED) & w_accept & (w_hit_next == w_hits)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b0;
            r_wake        <= 1'b0;
            r_irq         <= 1'b0;
            r_hit_cnt     <= '0;
            r_win_cnt     <= '0;
            r_cnt         <= '0;
            r_cfg_hits    <= '0;
            r_cfg_window  <= '0;
            r_cfg_sustain <= '0;
            r_cfg_holdoff <= '0;
        end else begin
            r_ready <= 1'b1;
            if (r_state == S_IDLE) begin
                r_cfg_hits    <= cfg_hits_i;
                r_cfg_window  <= cfg_window_i;
                r_cfg_sustain <= cfg_sustain_i;
                r_cfg_holdoff <= cfg_holdoff_i;
            end

            // A new wake outranks a simultaneous host acknowledge
            if (w_to_wake) begin
                r_irq <= 1'b1;
            end else if (irq_ack_i) begin
                r_irq <= 1'b0;
            end

            if (!enable_i) begin
                r_state   <= S_IDLE;
                r_wake    <= 1'b0;
                r_hit_cnt <= '0;
                r_win_cnt <= '0;
                r_cnt     <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_hit) begin
                            r_hit_cnt <= WIN_BW'(1);
                            if (w_to_wake) begin
                                r_state <= S_WAKE;
                                r_wake  <= 1'b1;
                                r_cnt   <= CNT_BW'(1);
                            end else begin
                                r_state   <= S_ARMED;
                                r_win_cnt <= WIN_BW'(1);
                            end
                        end
                    end
                    S_ARMED: begin
                        if (w_accept) begin
                            r_hit_cnt <= w_hit_next;
                            r_win_cnt <= w_win_next;
                            if (w_to_wake) begin
                                r_state <= S_WAKE;
                                r_wake  <= 1'b1;
                                r_cnt   <= CNT_BW'(1);
                            end else if ((w_win_next == w_window) || last_i) begin
                                r_state   <= S_IDLE;
                                r_hit_cnt <= '0;
                                r_win_cnt <= '0;
                            end
                        end
                    end
                    S_WAKE: begin
                        if (r_cnt == w_sustain) begin
                            r_wake    <= 1'b0;
                            r_hit_cnt <= '0;
                            r_win_cnt <= '0;
                            if (w_holdoff == '0) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= S_HOLDOFF;
                                r_cnt   <= CNT_BW'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_BW'(1);
                        end
                    end
                    S_HOLDOFF: begin
                        if (r_cnt == w_holdoff) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_BW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ready_o   = r_ready;
    assign wake_o    = r_wake;
    assign irq_o     = r_irq;
    assign hit_cnt_o = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wake_ctrl.sv
`default_nettype none
// tb_wake_ctrl : randomized + directed stimulus against an event-level
// reference model; expected outputs flow through a scoreboard queue.
module tb_wake_ctrl;
    localparam int NC = 3;
    localparam int WB = 8;
    localparam int CB = 16;
    localparam logic [NC-1:0] KW = 3'b001;
    localparam logic [NC-1:0] OT = 3'b010;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [NC-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          ready_o;
    logic          enable_i;
    logic [WB-1:0] cfg_hits_i;
    logic [WB-1:0] cfg_window_i;
    logic [CB-1:0] cfg_sustain_i;
    logic [CB-1:0] cfg_holdoff_i;
    logic          irq_ack_i;
    logic          wake_o;
    logic          irq_o;
    logic [WB-1:0] hit_cnt_o;

    wake_ctrl #(.NUM_CLASSES(NC), .WIN_BW(WB), .CNT_BW(CB)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .enable_i     (enable_i),
        .cfg_hits_i   (cfg_hits_i),
        .cfg_window_i (cfg_window_i),
        .cfg_sustain_i(cfg_sustain_i),
        .cfg_holdoff_i(cfg_holdoff_i),
        .irq_ack_i    (irq_ack_i),
        .wake_o       (wake_o),
        .irq_o        (irq_o),
        .hit_cnt_o    (hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          wake;
        logic          irq;
        logic          rdy;
        logic          hc_chk;
        logic [WB-1:0] hc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;
    int   checks = 0;
    int   errors = 0;

    // Reference model: edge counter plus the time spans of wake/dead periods
    int ecount = 0;
    bit m_ready = 0;
    bit m_irq = 0;
    bit m_act = 0;
    int m_hits = 0, m_len = 0;
    int m_H = 1, m_W = 1, m_S = 1, m_D = 0;
    int m_wake_from = 0, m_wake_to = -1, m_busy = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   acc, hit, trig;
        exp_t x;
        ecount++;
        trig = 0;
        if (!rst_n_i) begin
            m_ready = 0; m_irq = 0; m_act = 0; m_hits = 0; m_len = 0;
            m_wake_from = 0; m_wake_to = -1; m_busy = -1;
            x = '0;
            exp_q.push_back(x);
            return;
        end
        acc = valid_i && m_ready;
        hit = acc && data_i[0];
        if (!enable_i) begin
            m_act = 0; m_hits = 0; m_len = 0;
            m_wake_to = ecount - 1;
            m_busy = ecount;
        end else if (acc && ecount > m_busy) begin
            if (!m_act) begin
                if (hit) begin
                    m_H = (cfg_hits_i == 0) ? 1 : int'(cfg_hits_i);
                    m_W = (int'(cfg_window_i) < m_H) ? m_H : int'(cfg_window_i);
                    m_S = (cfg_sustain_i == 0) ? 1 : int'(cfg_sustain_i);
                    m_D = int'(cfg_holdoff_i);
                    m_act = 1; m_hits = 1; m_len = 1;
                    if (m_hits == m_H) trig = 1;
                end
            end else begin
                m_len++;
                if (hit) m_hits++;
                if (m_hits == m_H) trig = 1;
                else if (m_len == m_W || last_i) begin
                    m_act = 0; m_hits = 0; m_len = 0;
                end
            end
        end
        if (trig) begin
            m_wake_from = ecount;
            m_wake_to   = ecount + m_S - 1;
            m_busy      = ecount + m_S + m_D;
            m_act = 0; m_hits = 0; m_len = 0;
            m_irq = 1;
        end else if (irq_ack_i) begin
            m_irq = 0;
        end
        m_ready  = 1;
        x.wake   = (ecount >= m_wake_from) && (ecount <= m_wake_to);
        x.irq    = m_irq;
        x.rdy    = 1'b1;
        x.hc_chk = (ecount >= m_busy);
        x.hc     = WB'(m_act ? m_hits : 0);
        exp_q.push_back(x);
    endtask

    task automatic cyc(input bit v, input logic [NC-1:0] d, input bit l);
        valid_i = v; data_i = d; last_i = l;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        valid_i = 0; data_i = '0; last_i = 0; irq_ack_i = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0);
    endtask

    task automatic set_cfg(input int h, input int w, input int s, input int d);
        cfg_hits_i = WB'(h); cfg_window_i = WB'(w);
        cfg_sustain_i = CB'(s); cfg_holdoff_i = CB'(d);
    endtask

    task automatic ack();
        irq_ack_i = 1;
        cyc(0, '0, 0);
    endtask

    // Called at a falling edge: assert reset mid-cycle and expect instant clearing
    task automatic async_reset(input string nm);
        #2 rst_n_i = 0;
        #1;
        chk({nm, " wake_o"}, 32'(wake_o), 0);
        chk({nm, " irq_o"}, 32'(irq_o), 0);
        chk({nm, " hit_cnt_o"}, 32'(hit_cnt_o), 0);
        chk({nm, " ready_o"}, 32'(ready_o), 0);
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        rst_n_i = 1;
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                mx = exp_q.pop_front();
                chk("wake_o", 32'(wake_o), 32'(mx.wake));
                chk("irq_o", 32'(irq_o), 32'(mx.irq));
                chk("ready_o", 32'(ready_o), 32'(mx.rdy));
                if (mx.hc_chk) chk("hit_cnt_o", 32'(hit_cnt_o), 32'(mx.hc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 0; valid_i = 0; data_i = '0; last_i = 0;
        enable_i = 1; irq_ack_i = 0;
        set_cfg(1, 1, 4, 0);
        idle(3);
        rst_n_i = 1;
        idle(3);

        // single-hit wake, sustain 4, then acknowledge
        cyc(1, KW, 0); idle(6); ack(); idle(2);

        // 3 hits within 5 results
        set_cfg(3, 5, 2, 1);
        cyc(1, KW, 0); cyc(1, OT, 0); cyc(1, KW, 0); cyc(1, OT, 0); cyc(1, KW, 0);
        idle(6); ack();
        cyc(1, KW, 0); cyc(1, KW, 0); cyc(1, OT, 0); cyc(1, OT, 0); cyc(1, OT, 0);
        cyc(1, KW, 0); idle(2); cyc(1, OT, 1); idle(2);

        // segment end closes the window, but a hit on it still counts
        set_cfg(2, 8, 2, 0);
        cyc(1, KW, 0); cyc(1, KW, 1); idle(5); ack();
        cyc(1, KW, 0); cyc(1, OT, 1); idle(3);

        // results during wake and holdoff are discarded
        set_cfg(1, 1, 3, 10);
        cyc(1, KW, 0);
        for (int i = 0; i < 13; i++) cyc(1, KW, 0);
        idle(20); ack();

        // zero config clamps, and window stretched up to the hit count
        set_cfg(0, 0, 0, 0);
        cyc(1, KW, 0); idle(3); ack();
        set_cfg(9, 4, 2, 0);
        for (int i = 0; i < 8; i++) cyc(1, KW, 0);
        cyc(1, OT, 0); idle(2);
        for (int i = 0; i < 9; i++) cyc(1, KW, 0);
        idle(5);

        // enable dropped mid-wake truncates wake but keeps irq
        set_cfg(1, 1, 10, 2);
        cyc(1, KW, 0); idle(3);
        enable_i = 0; cyc(1, KW, 0);
        enable_i = 1; idle(4); ack(); idle(2);

        // asynchronous reset while armed and while waking
        set_cfg(3, 10, 5, 0);
        cyc(1, KW, 0); cyc(1, KW, 0);
        async_reset("rst_armed");
        idle(2);
        set_cfg(1, 1, 6, 0);
        cyc(1, KW, 0); idle(2);
        async_reset("rst_wake");
        idle(2);

        for (int blk = 0; blk < 12; blk++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 6),
                    $urandom_range(0, 5), $urandom_range(0, 4));
            for (int i = 0; i < 150; i++) begin
                enable_i  = ($urandom_range(0, 49) != 0);
                irq_ack_i = ($urandom_range(0, 9) == 0);
                cyc($urandom_range(0, 2) != 0, KW << $urandom_range(0, 2),
                    $urandom_range(0, 7) == 0);
            end
        end
        enable_i = 1;
        idle(30);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
